// File: rtl/memwb_stage_reg_if.sv
// Purpose : valid/ready payload link carrying one MEM/WB writeback entry.
// Latency : none (wires only).
// Backpressure: the slave drives ready; master holds valid and payload until taken.
//
// Signals:
//   valid  - entry present (master -> slave)
//   ready  - slave can take the entry (slave -> master)
//   wreg   - register-write strobe
//   m2reg  - writeback source select: 1 = mem, 0 = alu
//   rd     - destination register number
//   alu    - ALU result
//   mem    - memory read data
interface memwb_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              valid;
    logic              ready;
    logic              wreg;
    logic              m2reg;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;

    modport master (
        output valid, wreg, m2reg, rd, alu, mem,
        input  ready
    );

    modport slave (
        input  valid, wreg, m2reg, rd, alu, mem,
        output ready
    );
endinterface

// File: rtl/memwb_stage_reg.sv
// Purpose : elastic MEM/WB pipeline register (head + skid entry) that also forms
//           the final writeback data and the qualified register-file write strobe.
// Latency : 1 cycle in->out, full throughput; in_ready and out_valid are registered.
// Backpressure: up.ready drops only when both head and skid are full; payload holds while stalled.
//
// Ports:
//   clk, rst      - rising-edge clock, asynchronous active-high reset
//   flush         - drop every held and incoming entry at the next edge
//   up (slave)    - MEM-side entry: valid/ready + wreg, m2reg, rd, alu, mem
//   dn (master)   - WB-side head entry; dn.wreg is the qualified write strobe
//   wb_data       - dn.m2reg ? dn.mem : dn.alu
//   stall_cnt     - cycles with head valid and downstream not ready (MEMWB_PERF_EN)
//   flush_cnt     - flushes that hit at least one valid entry (MEMWB_PERF_EN)
// Optional feature macro: MEMWB_PERF_EN (undefined: counters read 0, no counter logic).
module memwb_stage_reg #(
    parameter int DATA_W         = 32,
    parameter int REG_W          = 5,
    parameter int ZERO_REG_GUARD = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    memwb_stage_reg_if.slave    up,
    memwb_stage_reg_if.master   dn,
    output logic [DATA_W-1:0]   wb_data,
    output logic [31:0]         stall_cnt,
    output logic [15:0]         flush_cnt
);

    localparam bit GUARD_R0 = (ZERO_REG_GUARD != 0);

    typedef struct packed {
        logic              wreg;
        logic              m2reg;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] mem;
    } payload_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t   state_q, state_d;
    logic     in_ready_q, in_ready_d;
    logic     out_valid_q, out_valid_d;
    payload_t head_q, head_d;
    payload_t skid_q, skid_d;
    payload_t in_pl;

    logic accept;
    logic consume;

    always_comb begin
        in_pl       = '0;
        in_pl.wreg  = up.wreg;
        in_pl.m2reg = up.m2reg;
        in_pl.rd    = up.rd;
        in_pl.alu   = up.alu;
        in_pl.mem   = up.mem;
    end

    // Both handshakes use only registered ready/valid on our side.
    assign accept  = up.valid && in_ready_q;
    assign consume = out_valid_q && dn.ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;

        if (flush) begin
            // Payload registers keep their stale contents; only occupancy clears.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        head_d  = in_pl;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        head_d = in_pl;
                    end else if (accept) begin
                        skid_d  = in_pl;
                        state_d = ST_TWO;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so accept cannot occur.
                    if (consume) begin
                        head_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head_q      <= '0;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
        end
    end

    assign up.ready = in_ready_q;
    assign dn.valid = out_valid_q;
    assign dn.m2reg = head_q.m2reg;
    assign dn.rd    = head_q.rd;
    assign dn.alu   = head_q.alu;
    assign dn.mem   = head_q.mem;
    // Strobe is gated by valid so stale head contents never write the regfile.
    assign dn.wreg  = head_q.wreg && out_valid_q && !(GUARD_R0 && (head_q.rd == '0));
    assign wb_data  = head_q.m2reg ? head_q.mem : head_q.alu;

`ifdef MEMWB_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid_q && !dn.ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        // A flush of an already-empty stage is not an event worth counting.
        if (flush && (state_q != ST_EMPTY) && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_memwb_stage_reg.sv
module tb_memwb_stage_reg;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] wb_data;
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;

    int total;
    int bad;

    memwb_stage_reg_if #(.DATA_W(32), .REG_W(5)) up_if ();
    memwb_stage_reg_if #(.DATA_W(32), .REG_W(5)) dn_if ();

    memwb_stage_reg #(.DATA_W(32), .REG_W(5), .ZERO_REG_GUARD(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .up        (up_if),
        .dn        (dn_if),
        .wb_data   (wb_data),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic m, input logic [4:0] r,
                         input logic [31:0] a, input logic [31:0] d);
        up_if.valid = v;
        up_if.wreg  = w;
        up_if.m2reg = m;
        up_if.rd    = r;
        up_if.alu   = a;
        up_if.mem   = d;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        flush = 1'b0;
        dn_if.ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        #1 rst = 1'b1;
        #2;
        total++; if (dn_if.valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", dn_if.valid); end
        total++; if (up_if.ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", up_if.ready); end
        total++; if (dn_if.wreg !== 1'b0) begin bad++; $display("FAIL reset_out_wreg got=%b exp=0", dn_if.wreg); end
        total++; if (dn_if.alu !== 32'd0 || dn_if.mem !== 32'd0 || dn_if.rd !== 5'd0) begin bad++; $display("FAIL reset_payload got alu=%h mem=%h rd=%0d exp=0", dn_if.alu, dn_if.mem, dn_if.rd); end
        total++; if (wb_data !== 32'd0) begin bad++; $display("FAIL reset_wb_data got=%h exp=0", wb_data); end
        total++; if (stall_cnt !== 32'd0 || flush_cnt !== 16'd0) begin bad++; $display("FAIL reset_counters got stall=%0d flush=%0d exp=0", stall_cnt, flush_cnt); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_stream();
        dn_if.ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 1'b0, 1'b0, 5'd1, i, 32'd0);
            step();
            total++; if (dn_if.valid !== 1'b1 || dn_if.alu !== i) begin bad++; $display("FAIL stream_%0d got valid=%b alu=%h exp valid=1 alu=%h", i, dn_if.valid, dn_if.alu, i); end
            total++; if (up_if.ready !== 1'b1) begin bad++; $display("FAIL stream_ready_%0d got=%b exp=1", i, up_if.ready); end
        end
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        step();
        total++; if (dn_if.valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", dn_if.valid); end
    endtask

    task automatic test_skid();
        dn_if.ready = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 5'd2, 32'h11, 32'd0);
        step();
        total++; if (dn_if.alu !== 32'h11 || up_if.ready !== 1'b1) begin bad++; $display("FAIL skid_a got alu=%h rdy=%b exp alu=11 rdy=1", dn_if.alu, up_if.ready); end
        drive(1'b1, 1'b0, 1'b0, 5'd2, 32'h22, 32'd0);
        step();
        total++; if (dn_if.alu !== 32'h11 || up_if.ready !== 1'b0) begin bad++; $display("FAIL skid_b got alu=%h rdy=%b exp alu=11 rdy=0", dn_if.alu, up_if.ready); end
        // Offer an entry while full: must not be taken.
        drive(1'b1, 1'b0, 1'b0, 5'd2, 32'h99, 32'd0);
        step();
        total++; if (dn_if.valid !== 1'b1 || dn_if.alu !== 32'h11 || up_if.ready !== 1'b0) begin bad++; $display("FAIL skid_hold got v=%b alu=%h rdy=%b exp v=1 alu=11 rdy=0", dn_if.valid, dn_if.alu, up_if.ready); end
        dn_if.ready = 1'b1;
        step();
        total++; if (dn_if.alu !== 32'h22 || up_if.ready !== 1'b1) begin bad++; $display("FAIL skid_pop1 got alu=%h rdy=%b exp alu=22 rdy=1", dn_if.alu, up_if.ready); end
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        step();
        total++; if (dn_if.valid !== 1'b0) begin bad++; $display("FAIL skid_pop2 got v=%b alu=%h exp v=0 (0x99 must be dropped)", dn_if.valid, dn_if.alu); end
    endtask

    task automatic test_wb_data();
        dn_if.ready = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 5'd3, 32'h5, 32'hDEADBEEF);
        step();
        total++; if (wb_data !== 32'hDEADBEEF || dn_if.m2reg !== 1'b1) begin bad++; $display("FAIL wb_mem got=%h m2reg=%b exp=deadbeef m2reg=1", wb_data, dn_if.m2reg); end
        drive(1'b1, 1'b1, 1'b0, 5'd3, 32'h5, 32'hDEADBEEF);
        step();
        total++; if (wb_data !== 32'h5) begin bad++; $display("FAIL wb_alu got=%h exp=00000005", wb_data); end
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        step();
    endtask

    task automatic test_zero_reg();
        dn_if.ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 5'd0, 32'h1, 32'd0);
        step();
        total++; if (dn_if.valid !== 1'b1 || dn_if.wreg !== 1'b0) begin bad++; $display("FAIL wreg_r0 got v=%b wreg=%b exp v=1 wreg=0", dn_if.valid, dn_if.wreg); end
        drive(1'b1, 1'b1, 1'b0, 5'd7, 32'h1, 32'd0);
        step();
        total++; if (dn_if.wreg !== 1'b1 || dn_if.rd !== 5'd7) begin bad++; $display("FAIL wreg_r7 got wreg=%b rd=%0d exp wreg=1 rd=7", dn_if.wreg, dn_if.rd); end
        drive(1'b1, 1'b0, 1'b0, 5'd7, 32'h1, 32'd0);
        step();
        total++; if (dn_if.wreg !== 1'b0) begin bad++; $display("FAIL wreg_off got=%b exp=0", dn_if.wreg); end
        drive(1'b1, 1'b1, 1'b0, 5'd9, 32'h1, 32'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        step();
        total++; if (dn_if.wreg !== 1'b0 || dn_if.valid !== 1'b0) begin bad++; $display("FAIL wreg_idle got wreg=%b v=%b exp 0 0", dn_if.wreg, dn_if.valid); end
    endtask

    task automatic test_flush();
        dn_if.ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 5'd4, 32'h31, 32'd0);
        step();
        drive(1'b1, 1'b1, 1'b0, 5'd4, 32'h32, 32'd0);
        step();
        total++; if (up_if.ready !== 1'b0) begin bad++; $display("FAIL flush_fill got rdy=%b exp=0", up_if.ready); end
        flush = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 5'd4, 32'h33, 32'd0);
        step();
        flush = 1'b0;
        total++; if (dn_if.valid !== 1'b0 || up_if.ready !== 1'b1 || dn_if.wreg !== 1'b0) begin bad++; $display("FAIL flush_two got v=%b rdy=%b wreg=%b exp 0 1 0", dn_if.valid, up_if.ready, dn_if.wreg); end
`ifdef MEMWB_PERF_EN
        total++; if (flush_cnt !== 16'd1) begin bad++; $display("FAIL flush_cnt_1 got=%0d exp=1", flush_cnt); end
`else
        total++; if (flush_cnt !== 16'd0) begin bad++; $display("FAIL flush_cnt_off got=%0d exp=0", flush_cnt); end
`endif
        // Flush in ONE while an entry is accepted: that entry is dropped too.
        drive(1'b1, 1'b1, 1'b0, 5'd4, 32'h41, 32'd0);
        step();
        flush = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 5'd4, 32'h42, 32'd0);
        step();
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        step();
        total++; if (dn_if.valid !== 1'b0) begin bad++; $display("FAIL flush_drop got v=%b alu=%h exp v=0", dn_if.valid, dn_if.alu); end
        // Flushing an empty stage is not counted.
        flush = 1'b1;
        step();
        flush = 1'b0;
`ifdef MEMWB_PERF_EN
        total++; if (flush_cnt !== 16'd2) begin bad++; $display("FAIL flush_cnt_2 got=%0d exp=2", flush_cnt); end
`else
        total++; if (flush_cnt !== 16'd0) begin bad++; $display("FAIL flush_cnt_off2 got=%0d exp=0", flush_cnt); end
`endif
    endtask

    task automatic test_async_reset();
        // Clean start so the stall count is exactly the cycles stalled below.
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        dn_if.ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 5'd5, 32'h55, 32'hA5A5A5A5);
        step();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        repeat (5) step();
        total++; if (dn_if.valid !== 1'b1 || wb_data !== 32'hA5A5A5A5 || dn_if.wreg !== 1'b1) begin bad++; $display("FAIL stall_hold got v=%b wb=%h wreg=%b exp 1 a5a5a5a5 1", dn_if.valid, wb_data, dn_if.wreg); end
`ifdef MEMWB_PERF_EN
        total++; if (stall_cnt !== 32'd5) begin bad++; $display("FAIL stall_cnt_5 got=%0d exp=5", stall_cnt); end
`else
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL stall_cnt_off got=%0d exp=0", stall_cnt); end
`endif
        #2 rst = 1'b1;
        #1;
        total++; if (dn_if.valid !== 1'b0 || dn_if.wreg !== 1'b0 || up_if.ready !== 1'b1) begin bad++; $display("FAIL arst_ctl got v=%b wreg=%b rdy=%b exp 0 0 1", dn_if.valid, dn_if.wreg, up_if.ready); end
        total++; if (dn_if.alu !== 32'd0 || dn_if.mem !== 32'd0 || dn_if.rd !== 5'd0 || dn_if.m2reg !== 1'b0 || wb_data !== 32'd0) begin bad++; $display("FAIL arst_payload got alu=%h mem=%h rd=%0d m2reg=%b wb=%h exp all 0", dn_if.alu, dn_if.mem, dn_if.rd, dn_if.m2reg, wb_data); end
        total++; if (stall_cnt !== 32'd0 || flush_cnt !== 16'd0) begin bad++; $display("FAIL arst_counters got stall=%0d flush=%0d exp 0", stall_cnt, flush_cnt); end
        #2 rst = 1'b0;
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_stream();
        test_skid();
        test_wb_data();
        test_zero_reg();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
